// File: rtl/dct_pkg.sv
// Shared types and constants for the 4x4 forward integer core transform.
// Optional feature macro used by this codebase slice: DCT_NZ_COUNT_EN.
package dct_pkg;

    localparam int DEF_IN_W    = 8;
    localparam int DEF_COEFF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_COL  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_DC    = 2'b00;
    localparam mode_t MODE_H     = 2'b01;
    localparam mode_t MODE_V     = 2'b10;
    localparam mode_t MODE_PLANE = 2'b11;

endpackage

// File: rtl/dct4x4_core_if.sv
// Residual-in / coefficient-out handshake bundle for dct4x4_core.
// `DCT_NZ_COUNT_EN adds coeff_nz_count to the output side.
interface dct4x4_core_if #(
    parameter int IN_W    = 8,
    parameter int COEFF_W = 16
);

    logic [16*IN_W-1:0]    residual_flat;
    logic [1:0]            residual_mode;
    logic                  residual_ready;
    logic                  dct_busy;
    logic [16*COEFF_W-1:0] coeff_flat;
    logic [1:0]            coeff_mode;
    logic                  coeff_valid;
    logic                  coeff_ready;

`ifdef DCT_NZ_COUNT_EN
    logic [4:0]            coeff_nz_count;

    modport master (
        output residual_flat, residual_mode, residual_ready, coeff_ready,
        input  dct_busy, coeff_flat, coeff_mode, coeff_valid, coeff_nz_count
    );

    modport slave (
        input  residual_flat, residual_mode, residual_ready, coeff_ready,
        output dct_busy, coeff_flat, coeff_mode, coeff_valid, coeff_nz_count
    );
`else
    modport master (
        output residual_flat, residual_mode, residual_ready, coeff_ready,
        input  dct_busy, coeff_flat, coeff_mode, coeff_valid
    );

    modport slave (
        input  residual_flat, residual_mode, residual_ready, coeff_ready,
        output dct_busy, coeff_flat, coeff_mode, coeff_valid
    );
`endif

endinterface

// File: rtl/dct4_bfly.sv
// Combinational 4-point H.264 forward butterfly, shared by the row and column passes.
module dct4_bfly
    import dct_pkg::*;
#(
    parameter int COEFF_W = DEF_COEFF_W
) (
    input  logic signed [COEFF_W-1:0] a,
    input  logic signed [COEFF_W-1:0] b,
    input  logic signed [COEFF_W-1:0] c,
    input  logic signed [COEFF_W-1:0] d,
    output logic signed [COEFF_W-1:0] y0,
    output logic signed [COEFF_W-1:0] y1,
    output logic signed [COEFF_W-1:0] y2,
    output logic signed [COEFF_W-1:0] y3
);

    logic signed [COEFF_W-1:0] s0, s1, d0, d1;

    always_comb begin
        s0 = a + d;
        s1 = b + c;
        d0 = a - d;
        d1 = b - c;
        y0 = s0 + s1;
        y1 = (d0 <<< 1) + d1;
        y2 = s0 - s1;
        y3 = d0 - (d1 <<< 1);
    end

endmodule

// File: rtl/dct4x4_core.sv
// Forward 4x4 integer core transform: four row passes then four column passes, in place.
// Optional `DCT_NZ_COUNT_EN adds a nonzero-coefficient count alongside the block.
module dct4x4_core
    import dct_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int COEFF_W = DEF_COEFF_W
) (
    input logic          clk,
    input logic          rst,
    dct4x4_core_if.slave bus
);

    typedef logic signed [COEFF_W-1:0] coeff_t;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    mode_t             mode_q, mode_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    coeff_t            arr_q [16];
    coeff_t            arr_d [16];
    coeff_t            op    [4];
    coeff_t            res   [4];
    logic signed [IN_W-1:0] smp;
`ifdef DCT_NZ_COUNT_EN
    logic [4:0]        nz_q, nz_d, nz_col;
`endif

    // Rows are read along the array, columns across it; index is {row, col}.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (state_q == ST_COL) op[i] = arr_q[{2'(i), cnt_q}];
            else                   op[i] = arr_q[{cnt_q, 2'(i)}];
        end
    end

    dct4_bfly #(.COEFF_W(COEFF_W)) u_bfly (
        .a (op[0]),  .b (op[1]),  .c (op[2]),  .d (op[3]),
        .y0(res[0]), .y1(res[1]), .y2(res[2]), .y3(res[3])
    );

    // NOTE: next-state logic uses blocking assignments with every output defaulted first, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        arr_d   = arr_q;
        smp     = '0;
`ifdef DCT_NZ_COUNT_EN
        nz_d    = nz_q;
        nz_col  = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.residual_ready) begin
                    for (int i = 0; i < 16; i++) begin
                        smp      = bus.residual_flat[IN_W*i +: IN_W];
                        arr_d[i] = COEFF_W'(smp);
                    end
                    mode_d  = bus.residual_mode;
                    cnt_d   = '0;
                    state_d = ST_ROW;
`ifdef DCT_NZ_COUNT_EN
                    nz_d    = '0;
`endif
                end
            end
            ST_ROW: begin
                for (int i = 0; i < 4; i++) arr_d[{cnt_q, 2'(i)}] = res[i];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ST_COL;
            end
            ST_COL: begin
                for (int i = 0; i < 4; i++) begin
                    arr_d[{2'(i), cnt_q}] = res[i];
`ifdef DCT_NZ_COUNT_EN
                    nz_col = nz_col + {4'b0, (res[i] != '0)};
`endif
                end
`ifdef DCT_NZ_COUNT_EN
                nz_d  = nz_q + nz_col;
`endif
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_OUT;
                    valid_d = 1'b1;
                end
            end
            ST_OUT: begin
                // No new block is taken here; the handshake only returns us to IDLE.
                if (bus.coeff_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            // NOTE: the working array is also the visible coefficient output, so it is reset along with the control state.
            for (int i = 0; i < 16; i++) arr_q[i] <= '0;
`ifdef DCT_NZ_COUNT_EN
            nz_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            for (int i = 0; i < 16; i++) arr_q[i] <= arr_d[i];
`ifdef DCT_NZ_COUNT_EN
            nz_q    <= nz_d;
`endif
        end
    end

    assign bus.dct_busy    = busy_q;
    assign bus.coeff_mode  = mode_q;
    assign bus.coeff_valid = valid_q;
`ifdef DCT_NZ_COUNT_EN
    assign bus.coeff_nz_count = nz_q;
`endif

    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign bus.coeff_flat[COEFF_W*g +: COEFF_W] = arr_q[g];
    end

endmodule

// File: tb/tb_dct4x4_core.sv
// Directed-vector and random back-to-back bench for dct4x4_core against a matrix-product model.
module tb_dct4x4_core;
    import dct_pkg::*;

    localparam int IN_W    = 8;
    localparam int COEFF_W = 16;

    typedef logic [16*IN_W-1:0]    res_t;
    typedef logic [16*COEFF_W-1:0] cf_t;

    typedef struct {
        string name;
        res_t  res;
        mode_t mode;
        cf_t   exp;
        int    nz;
    } vec_t;

    localparam int CF [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    dct4x4_core_if #(.IN_W(IN_W), .COEFF_W(COEFF_W)) bus ();

    dct4x4_core #(.IN_W(IN_W), .COEFF_W(COEFF_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t fill(input logic [7:0] v);
        res_t r;
        for (int i = 0; i < 16; i++) r[IN_W*i +: IN_W] = v;
        return r;
    endfunction

    function automatic cf_t set_cf(input cf_t f, input int u, input int v, input int val);
        cf_t o = f;
        o[COEFF_W*(4*u+v) +: COEFF_W] = COEFF_W'(val);
        return o;
    endfunction

    // Reference: Y = Cf * X * Cf^T computed as plain integer matrix products.
    function automatic cf_t golden(input res_t r);
        int  x [4][4];
        int  t [4][4];
        int  y;
        cf_t o = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) x[i][j] = int'($signed(r[IN_W*(4*i+j) +: IN_W]));
        for (int i = 0; i < 4; i++)
            for (int v = 0; v < 4; v++) begin
                t[i][v] = 0;
                for (int j = 0; j < 4; j++) t[i][v] += x[i][j] * CF[v][j];
            end
        for (int u = 0; u < 4; u++)
            for (int v = 0; v < 4; v++) begin
                y = 0;
                for (int i = 0; i < 4; i++) y += CF[u][i] * t[i][v];
                o = set_cf(o, u, v, y);
            end
        return o;
    endfunction

    // Presents one block to an idle DUT and returns edges from accept to coeff_valid.
    task automatic send_and_wait(input res_t r, input mode_t m, output int lat);
        bus.residual_flat  = r;
        bus.residual_mode  = m;
        bus.residual_ready = 1'b1;
        tick();
        bus.residual_ready = 1'b0;
        lat = 0;
        while (bus.coeff_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_block(input string name);
        bus.coeff_ready = 1'b1;
        tick();
        bus.coeff_ready = 1'b0;
        check({name, ".released"}, 256'({bus.coeff_valid, bus.dct_busy}), 256'(2'b00));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   cw [4] = '{1, 2, 1, 1};
        int   rv [4] = '{1, -2, 1, -1};
        cf_t  e;
        cf_t  saved;
        res_t r;
        bit   stable;

        vecs[0] = '{"zero", fill(8'h00), MODE_H, '0, 0};
        vecs[1] = '{"ones", fill(8'h01), MODE_V, set_cf('0, 0, 0, 16), 1};
        r = '0; r[7:0] = 8'h80; e = '0;
        for (int u = 0; u < 4; u++) for (int v = 0; v < 4; v++) e = set_cf(e, u, v, -128 * cw[u] * cw[v]);
        vecs[2] = '{"dc_neg128", r, MODE_PLANE, e, 16};
        r = '0; r[31:24] = 8'h01; e = '0;
        for (int u = 0; u < 4; u++) for (int v = 0; v < 4; v++) e = set_cf(e, u, v, cw[u] * rv[v]);
        vecs[3] = '{"corner03", r, MODE_DC, e, 16};
        vecs[4] = '{"minus1", fill(8'hFF), MODE_DC, set_cf('0, 0, 0, -16), 1};

        rst = 1'b1;
        bus.residual_flat  = '0;
        bus.residual_mode  = '0;
        bus.residual_ready = 1'b0;
        bus.coeff_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.ctrl", 256'({bus.dct_busy, bus.coeff_valid, bus.coeff_mode}), 256'(4'b0));
        check("reset.flat", bus.coeff_flat, '0);

        for (int i = 0; i < 5; i++) begin
            send_and_wait(vecs[i].res, vecs[i].mode, lat);
            check({vecs[i].name, ".latency"}, 256'(lat), 256'(8));
            check({vecs[i].name, ".coeff"}, bus.coeff_flat, vecs[i].exp);
            check({vecs[i].name, ".mode"}, 256'(bus.coeff_mode), 256'(vecs[i].mode));
`ifdef DCT_NZ_COUNT_EN
            check({vecs[i].name, ".nz"}, 256'(bus.coeff_nz_count), 256'(vecs[i].nz));
`endif
            release_block(vecs[i].name);
        end

        // Backpressure: held for 20 cycles with stray residual_ready pulses.
        send_and_wait(fill(8'h7F), MODE_PLANE, lat);
        check("bp.latency", 256'(lat), 256'(8));
        check("bp.coeff", bus.coeff_flat, set_cf('0, 0, 0, 2032));
        saved  = bus.coeff_flat;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.residual_ready = ((k % 2) == 0);
            bus.residual_flat  = fill(8'h11);
            tick();
            if (bus.coeff_valid !== 1'b1 || bus.dct_busy !== 1'b1 ||
                bus.coeff_flat !== saved || bus.coeff_mode !== MODE_PLANE) stable = 1'b0;
        end
        bus.residual_ready = 1'b0;
        check("bp.stable", 256'(stable), 256'(1));
        release_block("bp");

        // Reset in the middle of a block.
        bus.residual_flat  = fill(8'h05);
        bus.residual_mode  = MODE_V;
        bus.residual_ready = 1'b1;
        tick();
        bus.residual_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.ctrl", 256'({bus.dct_busy, bus.coeff_valid}), 256'(2'b00));
        check("midrst.flat", bus.coeff_flat, '0);
        send_and_wait(vecs[2].res, vecs[2].mode, lat);
        check("midrst.latency", 256'(lat), 256'(8));
        check("midrst.coeff", bus.coeff_flat, vecs[2].exp);
        release_block("midrst");

        // Back-to-back random blocks with both sides always ready.
        begin
            cf_t   exp_q [$];
            mode_t mode_q [$];
            int    acc = 0, outs = 0, cyc = 0, last = -1;
            bit    was_idle;
            res_t  cur;
            cur = {$urandom, $urandom, $urandom, $urandom};
            bus.residual_flat  = cur;
            bus.residual_mode  = 2'($urandom);
            bus.residual_ready = 1'b1;
            bus.coeff_ready    = 1'b1;
            while (outs < 1000 && cyc < 15000) begin
                was_idle = (bus.dct_busy == 1'b0);
                tick();
                cyc++;
                if (was_idle && bus.residual_ready) begin
                    exp_q.push_back(golden(cur));
                    mode_q.push_back(bus.residual_mode);
                    if (last >= 0) check("b2b.spacing", 256'(cyc - last), 256'(10));
                    last = cyc;
                    acc++;
                    if (acc == 1000) bus.residual_ready = 1'b0;
                    else begin
                        cur = {$urandom, $urandom, $urandom, $urandom};
                        bus.residual_flat = cur;
                        bus.residual_mode = 2'($urandom);
                    end
                end
                if (bus.coeff_valid === 1'b1) begin
                    if (exp_q.size() == 0) check("b2b.spurious", 256'(1), 256'(0));
                    else begin
                        check("b2b.coeff", bus.coeff_flat, exp_q.pop_front());
                        check("b2b.mode", 256'(bus.coeff_mode), 256'(mode_q.pop_front()));
                    end
                    outs++;
                end
            end
            bus.coeff_ready    = 1'b0;
            bus.residual_ready = 1'b0;
            check("b2b.count", 256'(outs), 256'(1000));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
